// File: rtl/host_mem_bridge.sv
// Host-side initiator for a byte-addressed memory. Packs a byte stream into masked,
// aligned words for the write port and unpacks words from the async read port into a byte stream.

module host_mem_bridge_lane (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       we,
    input  logic [7:0] din,
    output logic [7:0] q,
    output logic       m
);
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= 8'h00;
            m <= 1'b0;
        end else if (we) begin
            q <= din;
            m <= 1'b1;
        end
    end
endmodule

module host_mem_bridge #(
    parameter int NUM_BYTES  = (1 << 21),
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 16,
    localparam int ADDR_WIDTH = $clog2(NUM_BYTES),
    localparam int LANES      = DATA_WIDTH / 8,
    localparam int MASK_WIDTH = LANES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [7:0]            wb_data,
    output logic                  rb_valid,
    input  logic                  rb_ready,
    output logic [7:0]            rb_data,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] hw_addr,
    output logic [DATA_WIDTH-1:0] hw_data,
    output logic [MASK_WIDTH-1:0] hw_mask,
    output logic                  hw_en,
    output logic [ADDR_WIDTH-1:0] hr_addr,
    input  logic [DATA_WIDTH-1:0] hr_data
);
    localparam int LB = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, WR_FILL, WR_FLUSH, RD_SEND} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   base;
    logic [LB-1:0]           lane;
    logic [LEN_WIDTH-1:0]    rem;
    logic [LANES-1:0][7:0]   wbuf;
    logic [LANES-1:0]        wmask;
    logic [LANES-1:0][7:0]   rd_word;
    logic                    cmd_fire, wb_fire, rb_fire, flush, last_lane;

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign wb_fire   = wb_valid && wb_ready;
    assign rb_fire   = rb_valid && rb_ready;
    assign flush     = (state == WR_FLUSH);
    assign last_lane = (lane == LB'(LANES - 1));
    assign rd_word   = hr_data;
    assign hr_addr   = base;
    assign rb_data   = (state == RD_SEND) ? rd_word[lane] : 8'h00;

    // Byte buffer and byte mask, one slice per lane; cleared when the word is issued.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        host_mem_bridge_lane u_lane (
            .clk   (clk),
            .reset (reset),
            .clr   (flush),
            .we    (wb_fire && (lane == LB'(g))),
            .din   (wb_data),
            .q     (wbuf[g]),
            .m     (wmask[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        wb_ready  = 1'b0;
        rb_valid  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && (cmd_len != '0))
                    state_nxt = cmd_write ? WR_FILL : RD_SEND;
            end
            WR_FILL: begin
                wb_ready = 1'b1;
                if (wb_valid && (last_lane || (rem == LEN_WIDTH'(1))))
                    state_nxt = WR_FLUSH;
            end
            WR_FLUSH: state_nxt = (rem == '0) ? IDLE : WR_FILL;
            RD_SEND: begin
                rb_valid = 1'b1;
                if (rb_ready && (rem == LEN_WIDTH'(1)))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base    <= '0;
            lane    <= '0;
            rem     <= '0;
            done    <= 1'b0;
            hw_en   <= 1'b0;
            hw_addr <= '0;
            hw_data <= '0;
            hw_mask <= '0;
        end else begin
            done  <= 1'b0;
            hw_en <= 1'b0;
            case (state)
                IDLE: if (cmd_fire) begin
                    base <= {cmd_addr[ADDR_WIDTH-1:LB], {LB{1'b0}}};
                    lane <= cmd_addr[LB-1:0];
                    rem  <= cmd_len;
                    if (cmd_len == '0) done <= 1'b1;
                end
                WR_FILL: if (wb_fire) begin
                    lane <= lane + LB'(1);
                    rem  <= rem - LEN_WIDTH'(1);
                end
                WR_FLUSH: begin
                    // done lands in the same cycle as the final hw_en
                    hw_en   <= 1'b1;
                    hw_addr <= base;
                    hw_data <= wbuf;
                    hw_mask <= wmask;
                    base    <= base + ADDR_WIDTH'(LANES);
                    lane    <= '0;
                    if (rem == '0) done <= 1'b1;
                end
                RD_SEND: if (rb_fire) begin
                    lane <= lane + LB'(1);
                    rem  <= rem - LEN_WIDTH'(1);
                    if (last_lane) base <= base + ADDR_WIDTH'(LANES);
                    if (rem == LEN_WIDTH'(1)) done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_host_mem_bridge.sv
// Directed bench for host_mem_bridge: table of write commands plus hand-written read,
// zero-length and mid-command reset sequences.

module tb_host_mem_bridge;
    localparam int NB = (1 << 21);
    localparam int AW = 21;
    localparam int LN = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [15:0]   cmd_len;
    logic          wb_valid, wb_ready;
    logic [7:0]    wb_data;
    logic          rb_valid, rb_ready;
    logic [7:0]    rb_data;
    logic          done;
    logic [AW-1:0] hw_addr;
    logic [63:0]   hw_data;
    logic [7:0]    hw_mask;
    logic          hw_en;
    logic [AW-1:0] hr_addr;
    logic [63:0]   hr_data;

    int tests = 0;
    int fails = 0;

    host_mem_bridge dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .rb_valid(rb_valid), .rb_ready(rb_ready), .rb_data(rb_data),
        .done(done),
        .hw_addr(hw_addr), .hw_data(hw_data), .hw_mask(hw_mask), .hw_en(hw_en),
        .hr_addr(hr_addr), .hr_data(hr_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    always_comb begin
        hr_data = '0;
        for (int k = 0; k < LN; k++) hr_data[k*8 +: 8] = mem_byte(hr_addr + AW'(k));
    end

    // Event monitor: records every write strobe and counts done pulses / port activity.
    int            hw_cnt = 0, done_cnt = 0, done_hw = 0, wb_seen = 0, rb_seen = 0;
    logic [AW-1:0] ev_addr [64];
    logic [7:0]    ev_mask [64];
    logic [63:0]   ev_data [64];

    always @(negedge clk) begin
        if (!reset) begin
            if (hw_en) begin
                if (hw_cnt < 64) begin
                    ev_addr[hw_cnt] = hw_addr;
                    ev_mask[hw_cnt] = hw_mask;
                    ev_data[hw_cnt] = hw_data;
                end
                hw_cnt++;
            end
            if (done) done_cnt++;
            if (done && hw_en) done_hw++;
            if (wb_ready) wb_seen++;
            if (rb_valid) rb_seen++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [15:0] l);
        int t = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
        while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
        if (!cmd_ready) timeout("cmd_accept");
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        wb_valid = 1'b1; wb_data = b;
        @(negedge clk);
        while (!wb_ready && t < 50) begin @(negedge clk); t++; end
        if (!wb_ready) timeout("wb_accept");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int d0);
        int t = 0;
        while (done_cnt == d0 && t < 100) begin @(negedge clk); t++; end
        if (done_cnt == d0) timeout("wait_done");
    endtask

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   len;
        logic [7:0]    b0;
        logic [7:0]    step;
        logic [1:0]    n;
        logic [AW-1:0] ea0;
        logic [7:0]    em0;
        logic [63:0]   ed0;
        logic [AW-1:0] ea1;
        logic [7:0]    em1;
        logic [63:0]   ed1;
    } wvec_t;

    wvec_t wv [5];

    initial begin
        int h0, d0, dh0, r0, w0, got;
        logic [7:0]    rd_b [4];
        logic [AW-1:0] rd_a [4];
        logic [7:0]    held;
        logic          held_v;

        wv[0] = '{addr:21'h100, len:16'd8, b0:8'h11, step:8'h11, n:2'd1,
                  ea0:21'h100, em0:8'hFF, ed0:64'h8877665544332211, ea1:'0, em1:'0, ed1:'0};
        wv[1] = '{addr:21'h103, len:16'd7, b0:8'hA0, step:8'h01, n:2'd2,
                  ea0:21'h100, em0:8'hF8, ed0:64'hA4A3A2A1A0000000,
                  ea1:21'h108, em1:8'h03, ed1:64'h000000000000A6A5};
        wv[2] = '{addr:21'(NB - 2), len:16'd4, b0:8'hB0, step:8'h01, n:2'd2,
                  ea0:21'(NB - 8), em0:8'hC0, ed0:64'hB1B0000000000000,
                  ea1:21'h000, em1:8'h03, ed1:64'h000000000000B3B2};
        wv[3] = '{addr:21'h205, len:16'd2, b0:8'hC0, step:8'h01, n:2'd1,
                  ea0:21'h200, em0:8'h60, ed0:64'h00C1C00000000000, ea1:'0, em1:'0, ed1:'0};
        wv[4] = '{addr:21'h300, len:16'd1, b0:8'h5C, step:8'h00, n:2'd1,
                  ea0:21'h300, em0:8'h01, ed0:64'h000000000000005C, ea1:'0, em1:'0, ed1:'0};

        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wb_valid = 1'b0; wb_data = '0; rb_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_wb_ready", wb_ready, 0);
        check("rst_rb_valid", rb_valid, 0);
        check("rst_done", done, 0);
        check("rst_hw_en", hw_en, 0);
        check("rst_hw_addr", hw_addr, 0);
        check("rst_hw_data", hw_data, 0);
        check("rst_hw_mask", hw_mask, 0);
        check("rst_hr_addr", hr_addr, 0);
        check("rst_rb_data", rb_data, 0);

        // zero-length write then read
        for (int w = 1; w >= 0; w--) begin
            h0 = hw_cnt; w0 = wb_seen; r0 = rb_seen; d0 = done_cnt;
            send_cmd(1'(w), 21'h40, 16'd0);
            @(negedge clk);
            check("len0_done_pulse", done, 1);
            @(negedge clk);
            check("len0_done_low", done, 0);
            repeat (2) @(negedge clk);
            check("len0_done_count", done_cnt - d0, 1);
            check("len0_no_hw_en", hw_cnt - h0, 0);
            check("len0_no_wb_ready", wb_seen - w0, 0);
            check("len0_no_rb_valid", rb_seen - r0, 0);
        end

        // reset after 3 of 8 bytes: partial word must be dropped
        h0 = hw_cnt; d0 = done_cnt;
        send_cmd(1'b1, 21'h300, 16'd8);
        for (int i = 0; i < 3; i++) send_byte(8'hE0 + 8'(i));
        wb_valid = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        check("rst_mid_cmd_ready", cmd_ready, 1);
        check("rst_mid_wb_ready", wb_ready, 0);
        repeat (5) @(negedge clk);
        check("rst_mid_no_hw_en", hw_cnt - h0, 0);
        check("rst_mid_no_done", done_cnt - d0, 0);

        // table of write commands
        for (int v = 0; v < 5; v++) begin
            h0 = hw_cnt; d0 = done_cnt; dh0 = done_hw; r0 = rb_seen;
            send_cmd(1'b1, wv[v].addr, wv[v].len);
            for (int i = 0; i < int'(wv[v].len); i++)
                send_byte(8'(wv[v].b0 + wv[v].step * 8'(i)));
            wb_valid = 1'b0;
            wait_done(d0);
            repeat (2) @(negedge clk);
            check($sformatf("wr%0d_hw_count", v), hw_cnt - h0, 64'(wv[v].n));
            for (int j = 0; j < int'(wv[v].n); j++) begin
                check($sformatf("wr%0d_w%0d_addr", v, j), ev_addr[h0 + j], (j == 0) ? wv[v].ea0 : wv[v].ea1);
                check($sformatf("wr%0d_w%0d_mask", v, j), ev_mask[h0 + j], (j == 0) ? wv[v].em0 : wv[v].em1);
                check($sformatf("wr%0d_w%0d_data", v, j), ev_data[h0 + j], (j == 0) ? wv[v].ed0 : wv[v].ed1);
            end
            check($sformatf("wr%0d_done_count", v), done_cnt - d0, 1);
            check($sformatf("wr%0d_done_with_hw_en", v), done_hw - dh0, 1);
            check($sformatf("wr%0d_no_rb_valid", v), rb_seen - r0, 0);
        end

        // read 0x106 len 4 with random back-pressure
        h0 = hw_cnt; d0 = done_cnt; w0 = wb_seen;
        send_cmd(1'b0, 21'h106, 16'd4);
        got = 0; held = '0; held_v = 1'b0;
        for (int c = 0; c < 200 && got < 4; c++) begin
            @(negedge clk);
            if (held_v && rb_valid) check("rd_hold_stable", rb_data, held);
            held_v = 1'b0;
            if (rb_valid) begin
                rb_ready = (c == 0) ? 1'b0 : 1'($urandom_range(0, 1));
                if (rb_ready) begin
                    rd_b[got] = rb_data; rd_a[got] = hr_addr; got++;
                end else begin
                    held = rb_data; held_v = 1'b1;
                end
            end else begin
                rb_ready = 1'b0;
            end
        end
        @(posedge clk);
        #1 rb_ready = 1'b0;
        check("rd_byte_count", got, 4);
        for (int k = 0; k < 4 && k < got; k++) begin
            check($sformatf("rd%0d_data", k), rd_b[k], mem_byte(21'h106 + 21'(k)));
            check($sformatf("rd%0d_hr_addr", k), rd_a[k], (k < 2) ? 21'h100 : 21'h108);
        end
        repeat (3) @(negedge clk);
        check("rd_done_count", done_cnt - d0, 1);
        check("rd_no_hw_en", hw_cnt - h0, 0);
        check("rd_no_wb_ready", wb_seen - w0, 0);
        check("rd_idle_after", cmd_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
